// File: rtl/sram_arb_pkg.sv
// Shared types for the framebuffer SRAM arbiter.
// Clear FSM states and SRAM port owner encoding.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_CLR  = 2'd2,
    GNT_WR   = 2'd3
  } gnt_e;

endpackage

// File: rtl/sram_clear_seq.sv
// Clear engine: walks addresses 0..DEPTH-1 writing a latched fill value.
// Only built into sram_arbiter when SRAM_ARB_CLEAR_EN is defined.
module sram_clear_seq
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_fill,
  input  logic                  i_grant,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] fill;

  assign o_addr = cnt;
  assign o_data = fill;

  // Counter only moves on cycles the arbiter actually gave us.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fill   <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state  <= CLEAR;
            cnt    <= '0;
            fill   <= i_fill;
            o_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (i_grant) begin
            if (cnt == LAST) begin
              state  <= DONE;
              cnt    <= '0;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port framebuffer SRAM arbiter: display read > clear > draw write.
// Clear engine present only when SRAM_ARB_CLEAR_EN is defined.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic                  i_clr_start,
  input  logic [DATA_WIDTH-1:0] i_clr_data,
  output logic                  o_clr_busy,
  output logic                  o_clr_done,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_write,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  input  logic [DATA_WIDTH-1:0] i_sram_data
);

  gnt_e                  gnt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;

`ifdef SRAM_ARB_CLEAR_EN
  logic clr_grant;

  assign clr_grant = (gnt == GNT_CLR);

  sram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_clr_start),
    .i_fill  (i_clr_data),
    .i_grant (clr_grant),
    .o_busy  (o_clr_busy),
    .o_done  (o_clr_done),
    .o_addr  (clr_addr),
    .o_data  (clr_data)
  );
`else
  logic unused_clr;

  assign unused_clr = ^{i_clr_start, i_clr_data};
  assign clr_addr   = '0;
  assign clr_data   = '0;
  assign o_clr_busy = 1'b0;
  assign o_clr_done = 1'b0;
`endif

  // Draw side may only move when neither read nor clear wants the port.
  assign o_wr_ready = !i_rd_req && !o_clr_busy;

  always_comb begin
    gnt = GNT_NONE;
    if (i_rd_req) begin
      gnt = GNT_RD;
    end else if (o_clr_busy) begin
      gnt = GNT_CLR;
    end else if (i_wr_valid) begin
      gnt = GNT_WR;
    end
  end

  always_comb begin
    o_sram_addr  = '0;
    o_sram_data  = '0;
    o_sram_write = 1'b0;
    unique case (gnt)
      GNT_RD: begin
        o_sram_addr = i_rd_addr;
      end
      GNT_CLR: begin
        o_sram_addr  = clr_addr;
        o_sram_data  = clr_data;
        o_sram_write = 1'b1;
      end
      GNT_WR: begin
        o_sram_addr  = i_wr_addr;
        o_sram_data  = i_wr_data;
        o_sram_write = 1'b1;
      end
      default: begin
        o_sram_addr = '0;
      end
    endcase
  end

  // SRAM output is already registered; only the valid needs a stage.
  assign o_rd_data = i_sram_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_req;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 1-cycle SRAM.
// Clear-engine steps run when SRAM_ARB_CLEAR_EN is defined.
module tb_sram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          clr_start;
  logic [DW-1:0] clr_data;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] sram_addr;
  logic          sram_write;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_q;

  logic [DW-1:0] mem [256];

  int n_vec = 0;
  int n_err = 0;
  int bad;
  int busy_n;
  int done_k;
  int done_n;
  int wr_n;
  logic prev_rd;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_write) mem[sram_addr] <= sram_wdata;
    else sram_q <= mem[sram_addr];
  end

  sram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (256)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rd_req     (rd_req),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .i_wr_valid   (wr_valid),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_ready   (wr_ready),
    .i_clr_start  (clr_start),
    .i_clr_data   (clr_data),
    .o_clr_busy   (clr_busy),
    .o_clr_done   (clr_done),
    .o_sram_addr  (sram_addr),
    .o_sram_write (sram_write),
    .o_sram_data  (sram_wdata),
    .i_sram_data  (sram_q)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a,
                    input logic [DW-1:0] exp,
                    input string tag);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    #1;
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    rd_req = 1'b1;
    rd_addr = '0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_start = 1'b0;
    clr_data = '0;
    repeat (2) tick();
    check("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    rd_req = 1'b0;
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    check("rst_sram_write", sram_write, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_data", sram_wdata, 0);

    // single write then read back
    wr_valid = 1'b1;
    wr_addr = 8'h10;
    wr_data = 8'hA5;
    #1;
    check("wr_ready", wr_ready, 1);
    check("wr_sram_write", sram_write, 1);
    check("wr_sram_addr", sram_addr, 8'h10);
    check("wr_sram_data", sram_wdata, 8'hA5);
    tick();
    wr_valid = 1'b0;
    rd_req = 1'b1;
    rd_addr = 8'h10;
    #1;
    check("rd_sram_write", sram_write, 0);
    check("rd_sram_addr", sram_addr, 8'h10);
    check("rd_wr_ready", wr_ready, 0);
    tick();
    rd_req = 1'b0;
    #1;
    check("rd_valid", rd_valid, 1);
    check("rd_data", rd_data, 8'hA5);
    tick();
    check("rd_valid_off", rd_valid, 0);

    // preload mem[i] = i*3+1
    for (int i = 0; i < 256; i++) begin
      wr_valid = 1'b1;
      wr_addr = 8'(i);
      wr_data = 8'(i * 3 + 1);
      tick();
    end
    wr_valid = 1'b0;

    // back-to-back reads
    rd_req = 1'b1;
    rd_addr = 8'h00;
    tick();
    rd_addr = 8'h01;
    #1;
    check("b2b_v0", rd_valid, 1);
    check("b2b_d0", rd_data, 8'h01);
    tick();
    rd_addr = 8'hFF;
    #1;
    check("b2b_v1", rd_valid, 1);
    check("b2b_d1", rd_data, 8'h04);
    tick();
    rd_req = 1'b0;
    #1;
    check("b2b_v2", rd_valid, 1);
    check("b2b_d2", rd_data, 8'hFE);

    // 8 reads hold off a pending draw write
    tick();
    wr_valid = 1'b1;
    wr_addr = 8'h20;
    wr_data = 8'h77;
    rd_req = 1'b1;
    rd_addr = 8'h20;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("hold_ready", wr_ready, 0);
      check("hold_write", sram_write, 0);
      tick();
      check("hold_valid", rd_valid, 1);
      check("hold_data", rd_data, 8'h61);
    end
    rd_req = 1'b0;
    #1;
    check("land_ready", wr_ready, 1);
    check("land_write", sram_write, 1);
    check("land_addr", sram_addr, 8'h20);
    check("land_data", sram_wdata, 8'h77);
    tick();
    wr_valid = 1'b0;
    check("land_rd_valid", rd_valid, 0);
    rd(8'h20, 8'h77, "rd_after_wr");

    // idle port drives zeros
    wr_addr = 8'h33;
    wr_data = 8'h44;
    rd_addr = 8'h55;
    #1;
    check("idle_addr", sram_addr, 0);
    check("idle_data", sram_wdata, 0);
    check("idle_write", sram_write, 0);

`ifdef SRAM_ARB_CLEAR_EN
    // clear start coincident with a draw write
    tick();
    wr_valid = 1'b1;
    wr_addr = 8'h05;
    wr_data = 8'h99;
    clr_start = 1'b1;
    clr_data = 8'h3C;
    #1;
    check("cw_write", sram_write, 1);
    check("cw_addr", sram_addr, 8'h05);
    check("cw_data", sram_wdata, 8'h99);
    tick();
    wr_valid = 1'b0;
    clr_start = 1'b0;
    bad = 0;
    busy_n = 0;
    done_k = 0;
    for (int k = 1; k <= 300; k++) begin
      clr_start = (k == 10);
      clr_data = (k == 10) ? 8'hFF : 8'h00;
      wr_valid = (k == 20);
      wr_addr = 8'h07;
      wr_data = 8'hE1;
      #1;
      if (clr_busy) begin
        busy_n++;
        if (!sram_write || sram_addr != 8'(k - 1) ||
            sram_wdata != 8'h3C || wr_ready) bad++;
      end
      if (clr_done) begin
        if (done_k == 0) done_k = k;
        else bad++;
        if (!wr_ready) bad++;
      end
      tick();
    end
    clr_start = 1'b0;
    wr_valid = 1'b0;
    check("clr_busy_cycles", busy_n, 256);
    check("clr_done_cycle", done_k, 257);
    check("clr_bad", bad, 0);
    rd(8'h00, 8'h3C, "clr_rd0");
    rd(8'h05, 8'h3C, "clr_rd5");
    rd(8'h07, 8'h3C, "clr_rd7");
    rd(8'h80, 8'h3C, "clr_rd128");
    rd(8'hFF, 8'h3C, "clr_rd255");

    // clear interleaved with reads
    tick();
    clr_start = 1'b1;
    clr_data = 8'hC7;
    tick();
    clr_start = 1'b0;
    rd_addr = 8'h00;
    prev_rd = 1'b0;
    bad = 0;
    wr_n = 0;
    done_n = 0;
    done_k = 0;
    for (int k = 1; k <= 520; k++) begin
      rd_req = (k % 2 == 0) && (k <= 510);
      #1;
      if (prev_rd && (!rd_valid || rd_data != 8'hC7)) bad++;
      if (rd_req && sram_write) bad++;
      if (sram_write) wr_n++;
      if (clr_done) begin
        done_n++;
        done_k = k;
      end
      prev_rd = rd_req;
      tick();
    end
    rd_req = 1'b0;
    check("il_writes", wr_n, 256);
    check("il_done_n", done_n, 1);
    check("il_done_k", done_k, 512);
    check("il_bad", bad, 0);

    // reset while clearing address 100
    clr_start = 1'b1;
    clr_data = 8'h11;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    #1;
    check("mid_addr", sram_addr, 8'd100);
    check("mid_busy", clr_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_busy_off", clr_busy, 0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (sram_write || clr_done || clr_busy) bad++;
      tick();
    end
    check("mid_quiet", bad, 0);
    rd(8'd99, 8'h11, "mid_rd99");
    rd(8'd100, 8'h11, "mid_rd100");
    rd(8'd101, 8'hC7, "mid_rd101");
    rd(8'd255, 8'hC7, "mid_rd255");
`else
    // clear request has no effect without the engine
    tick();
    clr_start = 1'b1;
    clr_data = 8'hEE;
    #1;
    check("nc_write", sram_write, 0);
    tick();
    clr_start = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (clr_busy || clr_done || sram_write || !wr_ready) bad++;
      tick();
    end
    check("nc_quiet", bad, 0);
    check("nc_busy", clr_busy, 0);
    check("nc_done", clr_done, 0);
    rd(8'h00, 8'h01, "nc_rd0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Arbiter and sequencer in front of one single-port synchronous SRAM (1-cycle registered read, no read data on write cycles). Shares the SRAM between a display read client (pixel fetch, strict priority, never stalled) and a drawing write client (valid/ready). An optional clear engine fills the whole array with one value. Sits between the VGA timing/pixel pipeline and the framebuffer SRAM instance.

## Interface
- ADDR_WIDTH, 8, SRAM address width
- DATA_WIDTH, 8, SRAM data width
- DEPTH, 256, number of words; legal 2..2^ADDR_WIDTH
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_rd_req  in  1  display read request this cycle
- i_rd_addr  in  ADDR_WIDTH  display read address
- o_rd_data  out  DATA_WIDTH  read data; meaningful only when o_rd_valid=1
- o_rd_valid  out  1  read data valid, one cycle after the granted request
- i_wr_valid  in  1  draw write request
- i_wr_addr  in  ADDR_WIDTH  draw write address
- i_wr_data  in  DATA_WIDTH  draw write data
- o_wr_ready  out  1  write accepted this cycle when i_wr_valid & o_wr_ready
- i_clr_start  in  1  start clear; 1-cycle pulse
- i_clr_data  in  DATA_WIDTH  fill value, sampled on accepted i_clr_start
- o_clr_busy  out  1  clear in progress
- o_clr_done  out  1  1-cycle pulse after the last clear write
- o_sram_addr  out  ADDR_WIDTH  to SRAM address
- o_sram_write  out  1  to SRAM write enable
- o_sram_data  out  DATA_WIDTH  to SRAM write data
- i_sram_data  in  DATA_WIDTH  from SRAM read data

## Operation
- Per cycle, exactly one owner of the SRAM port, priority: read > clear > draw write > idle.
- Read grant: i_rd_req=1 always granted; o_sram_addr=i_rd_addr, o_sram_write=0.
- Clear grant: o_clr_busy=1 and no read; o_sram_addr=clear counter, o_sram_data=latched fill, o_sram_write=1; counter advances only on granted cycles.
- Draw grant: o_wr_ready = !i_rd_req & !o_clr_busy (combinational); on handshake o_sram_write=1 with draw addr/data. o_wr_ready independent of i_wr_valid.
- Idle: o_sram_write=0, o_sram_addr=0, o_sram_data=0.
- o_rd_data = i_sram_data (pass-through; SRAM output already registered).
- Clear FSM states: IDLE -> (i_clr_start) CLEAR -> (granted write at DEPTH-1) DONE -> IDLE. DONE lasts one cycle, asserts o_clr_done; o_clr_busy=1 only in CLEAR.
- Counter: ADDR_WIDTH bits, starts 0, compared to DEPTH-1 (no wrap past DEPTH-1 when DEPTH < 2^ADDR_WIDTH).
- i_clr_start in CLEAR or DONE: ignored, fill value not re-latched.
- Writes during clear blocked (o_wr_ready=0); reads continue and delay the clear.

## Timing
- Reset values: o_rd_valid=0, o_clr_busy=0, o_clr_done=0, FSM=IDLE, counter=0, fill latch=0; combinational outputs follow the idle/grant rules from the first post-reset cycle.
- Read latency: request at cycle N -> o_rd_valid=1 and data at N+1; back-to-back reads give back-to-back valid.
- o_rd_valid register = i_rd_req of previous cycle (forced 0 in reset cycle).
- Write: committed at the handshake edge; a read of the same address at N+1 returns new data.
- Clear with no reads: start at N -> writes N+1..N+DEPTH, o_clr_done at N+DEPTH+1, o_wr_ready=1 again at N+DEPTH+1.
- Reset mid-clear: next cycle FSM=IDLE, no further clear writes, o_clr_done not pulsed.
- Simultaneous i_clr_start and i_wr_valid in IDLE with o_wr_ready=1: write completes that cycle, clear starts next.

## Configuration
- SRAM_ARB_CLEAR_EN defined: clear engine built as above.
- Undefined: no FSM/counter; i_clr_start, i_clr_data ignored; o_clr_busy=0, o_clr_done=0 constant; o_wr_ready = !i_rd_req. Port list unchanged.

## Structure
- Shared package sram_arb_pkg: clear FSM state encoding (IDLE, CLEAR, DONE) and grant-owner encoding (GNT_NONE, GNT_RD, GNT_CLR, GNT_WR).
- One sub-module: sram_clear_seq (FSM, counter, fill latch; inputs grant, outputs busy/done/addr/data), instantiated only under SRAM_ARB_CLEAR_EN.

## Test plan
- Write addr 0x10=0xA5 with no reads (ready=1) -> read 0x10 -> o_rd_valid and o_rd_data=0xA5 one cycle later.
- i_rd_req held 8 cycles with i_wr_valid=1 -> o_wr_ready=0 throughout; write lands the cycle i_rd_req drops; 8 consecutive o_rd_valid.
- Clear with fill 0x3C, DEPTH=256, no reads -> o_clr_busy 256 cycles, o_clr_done at start+257, every address reads 0x3C.
- Clear with reads every other cycle -> clear takes 512 granted-slot cycles, no read corrupted, done pulses once.
- i_rst at clear address 100 -> busy drops next cycle, addresses 101..255 keep old contents, no done pulse.
- Build without SRAM_ARB_CLEAR_EN, pulse i_clr_start -> no SRAM writes, o_clr_busy/o_clr_done stay 0.
